// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron I/O queues: default byte width, queue depth
// and the occupancy-counter width helper.
package neuron_pkg;

  localparam int NEURON_DW        = 8;
  localparam int NEURON_INQ_DEPTH = 4;

  // Occupancy must represent 0..depth inclusive, hence one bit above the pointer width.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/neuron_inq_if.sv
// Host/core handshake bundle of the neuron input queue: host push side
// (valid/ready/data) and core pop side (take/have/head byte).
interface neuron_inq_if #(
  parameter int DW = 8
);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          in_take;
  logic          have_in;
  logic [DW-1:0] in_data_r;

  modport master (
    output in_valid, in_data, in_take,
    input  in_ready, have_in, in_data_r
  );

  modport slave (
    input  in_valid, in_data, in_take,
    output in_ready, have_in, in_data_r
  );

endinterface

// File: rtl/neuron_fifo_mem.sv
// DEPTH x DW register array for the neuron queues: one synchronous write port,
// one asynchronous read port. Contents are never reset.
module neuron_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DW-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DW-1:0]            o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/neuron_inq.sv
// Neuron input queue: host pushes bytes via valid/ready, core pops the head with in_take.
// Optional drop counter on ovf_count enabled by defining NEURON_INQ_OVF_CNT_EN.
module neuron_inq
  import neuron_pkg::*;
#(
  parameter int DEPTH = NEURON_INQ_DEPTH,
  parameter int DW    = NEURON_DW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  neuron_inq_if.slave               bus,
  output logic [level_w(DEPTH)-1:0] level,
  output logic                      ovf,
  input  logic                      ovf_clr,
  output logic [7:0]                ovf_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_ovf;

  logic          w_clr;
  logic          w_full;
  logic          w_have;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [DW-1:0] w_rd_data;

  // ena low behaves exactly like reset, so both collapse into one clear term.
  assign w_clr   = rst || !ena;
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_have  = (r_level != '0);
  assign w_ready = ena && !w_full;
  assign w_push  = bus.in_valid && w_ready;
  assign w_pop   = bus.in_take && w_have;
  assign w_drop  = bus.in_valid && !w_ready && ena;

  neuron_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push && !rst),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      // Occupancy tracked explicitly; pointers alone cannot tell full from empty.
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

`ifdef NEURON_INQ_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_ovf_cnt <= 8'd0;
    end else if (ovf_clr) begin
      r_ovf_cnt <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop && (r_ovf_cnt != 8'd255)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign ovf_count = r_ovf_cnt;
`else
  assign ovf_count = 8'd0;
`endif

  assign bus.in_ready  = w_ready;
  assign bus.have_in   = w_have;
  assign bus.in_data_r = w_have ? w_rd_data : '0;
  assign level         = r_level;
  assign ovf           = r_ovf;

endmodule

// File: tb/tb_neuron_inq.sv
// Bench for neuron_inq: directed vector table, hand-written corner sequences
// and randomized traffic, all compared against a queue-based reference model.
module tb_neuron_inq;

  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       ovf_clr;
  logic [2:0] level;
  logic       ovf;
  logic [7:0] ovf_count;

  neuron_inq_if #(.DW(DW)) bus ();

  neuron_inq #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .bus       (bus),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: plain byte queue plus flags.
  byte unsigned m_q[$];
  bit           m_ovf;
  int           m_cnt;

  typedef struct {
    bit        r, e, v, t, c;
    logic [7:0] d;
    int        lvl;
    int        head;
    bit        xovf;
    bit        rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, e, v, t, c, input logic [7:0] d);
    bit rdy, drop;
    if (r || !e) begin
      m_q.delete();
      m_ovf = 0;
      m_cnt = 0;
    end else begin
      rdy  = (m_q.size() < DEPTH);
      drop = v && !rdy;
      if (t && m_q.size() > 0) void'(m_q.pop_front());
      if (v && rdy) m_q.push_back(d);
      if (drop)   m_ovf = 1;
      else if (c) m_ovf = 0;
      if (c)                       m_cnt = drop ? 1 : 0;
      else if (drop && m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic step(input bit r, e, v, t, c, input logic [7:0] d);
    int exp_cnt;
    @(negedge clk);
    rst = r; ena = e; ovf_clr = c;
    bus.in_valid = v; bus.in_data = d; bus.in_take = t;
    @(posedge clk);
    model_edge(r, e, v, t, c, d);
    #1;
`ifdef NEURON_INQ_OVF_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    chk("level",     int'(level),         m_q.size());
    chk("have_in",   int'(bus.have_in),   int'(m_q.size() != 0));
    chk("in_data_r", int'(bus.in_data_r), (m_q.size() != 0) ? int'(m_q[0]) : 0);
    chk("in_ready",  int'(bus.in_ready),  int'(e && m_q.size() < DEPTH));
    chk("ovf",       int'(ovf),           int'(m_ovf));
    chk("ovf_count", int'(ovf_count),     exp_cnt);
  endtask

  function automatic vec_t mk(bit r, e, v, logic [7:0] d, bit t, c,
                              int lvl, int head, bit xovf, bit rdy);
    vec_t x;
    x.r = r; x.e = e; x.v = v; x.d = d; x.t = t; x.c = c;
    x.lvl = lvl; x.head = head; x.xovf = xovf; x.rdy = rdy;
    return x;
  endfunction

  initial begin
    rst = 1'b1; ena = 1'b1; ovf_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_take = 1'b0;

    //        r e v d      t c  lvl head ovf rdy
    tbl.push_back(mk(1,1,1,8'hEE,0,0, 0,8'h00,0,1)); // reset with in_valid held
    tbl.push_back(mk(0,1,1,8'hA1,0,0, 1,8'hA1,0,1));
    tbl.push_back(mk(0,1,1,8'hB2,0,0, 2,8'hA1,0,1));
    tbl.push_back(mk(0,1,1,8'hC3,0,0, 3,8'hA1,0,1));
    tbl.push_back(mk(0,1,0,8'h00,1,0, 2,8'hB2,0,1));
    tbl.push_back(mk(0,1,0,8'h00,1,0, 1,8'hC3,0,1));
    tbl.push_back(mk(0,1,0,8'h00,1,0, 0,8'h00,0,1));
    tbl.push_back(mk(0,1,0,8'h00,1,0, 0,8'h00,0,1)); // take while empty ignored
    tbl.push_back(mk(0,1,1,8'h10,0,0, 1,8'h10,0,1));
    tbl.push_back(mk(0,1,1,8'h11,0,0, 2,8'h10,0,1));
    tbl.push_back(mk(0,1,1,8'h12,0,0, 3,8'h10,0,1));
    tbl.push_back(mk(0,1,1,8'h13,0,0, 4,8'h10,0,0));
    tbl.push_back(mk(0,1,1,8'h55,0,0, 4,8'h10,1,0)); // dropped
    tbl.push_back(mk(0,1,0,8'h00,1,0, 3,8'h11,1,1));
    tbl.push_back(mk(0,1,0,8'h00,1,0, 2,8'h12,1,1));
    tbl.push_back(mk(0,1,0,8'h00,1,0, 1,8'h13,1,1));
    tbl.push_back(mk(0,1,0,8'h00,1,0, 0,8'h00,1,1));
    tbl.push_back(mk(0,1,0,8'h00,0,1, 0,8'h00,0,1)); // ovf_clr
    tbl.push_back(mk(0,1,1,8'h20,0,0, 1,8'h20,0,1));
    tbl.push_back(mk(0,1,1,8'h21,0,0, 2,8'h20,0,1));
    tbl.push_back(mk(0,1,1,8'h77,1,0, 2,8'h21,0,1)); // push+pop mid-level
    tbl.push_back(mk(0,1,0,8'h00,1,0, 1,8'h77,0,1));
    tbl.push_back(mk(0,1,0,8'h00,1,0, 0,8'h00,0,1));
    tbl.push_back(mk(0,1,1,8'h30,0,0, 1,8'h30,0,1));
    tbl.push_back(mk(0,1,1,8'h31,0,0, 2,8'h30,0,1));
    tbl.push_back(mk(0,1,1,8'h32,0,0, 3,8'h30,0,1));
    tbl.push_back(mk(0,1,1,8'h33,0,0, 4,8'h30,0,0));
    tbl.push_back(mk(0,1,1,8'h44,1,0, 3,8'h31,1,1)); // full: push refused, pop taken
    tbl.push_back(mk(0,1,0,8'h00,1,0, 2,8'h32,1,1));
    tbl.push_back(mk(0,1,0,8'h00,1,0, 1,8'h33,1,1));
    tbl.push_back(mk(0,1,0,8'h00,1,1, 0,8'h00,0,1));
    tbl.push_back(mk(0,1,1,8'h01,0,0, 1,8'h01,0,1));
    tbl.push_back(mk(0,1,1,8'h02,0,0, 2,8'h01,0,1));
    tbl.push_back(mk(0,1,1,8'h03,0,0, 3,8'h01,0,1));
    tbl.push_back(mk(0,0,1,8'h04,0,0, 0,8'h00,0,0)); // ena=0 flush
    tbl.push_back(mk(0,1,0,8'h00,0,0, 0,8'h00,0,1));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].t, tbl[i].c, tbl[i].d);
      chk("tbl_level",  int'(level),         tbl[i].lvl);
      chk("tbl_head",   int'(bus.in_data_r), tbl[i].head);
      chk("tbl_ovf",    int'(ovf),           int'(tbl[i].xovf));
      chk("tbl_ready",  int'(bus.in_ready),  int'(tbl[i].rdy));
    end

    // Wrap: pointers pass DEPTH several times.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 0, 0, 8'(i));
      chk("wrap_head", int'(bus.in_data_r), i);
      step(0, 1, 0, 1, 0, 8'h00);
      chk("wrap_empty", int'(bus.have_in), 0);
    end

    // Drop in the same cycle as ovf_clr: set wins, counter restarts at one.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 0, 0, 8'(8'h60 + i));
    step(0, 1, 1, 0, 0, 8'hAA);
    step(0, 1, 1, 0, 0, 8'hAB);
    step(0, 1, 1, 0, 1, 8'hAC);
    chk("ovf_set_wins", int'(ovf), 1);
`ifdef NEURON_INQ_OVF_CNT_EN
    chk("cnt_after_clr_drop", int'(ovf_count), 1);
`else
    chk("cnt_disabled", int'(ovf_count), 0);
`endif
    step(0, 1, 0, 1, 0, 8'h00);
    chk("head_after_drops", int'(bus.in_data_r), 8'h61);
    step(1, 1, 1, 0, 0, 8'h99);
    chk("reset_level", int'(level), 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 29) != 0,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 1),
           $urandom_range(0, 9) == 0,
           8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
